c3aibadapt_avmm_hrdrst_osc_ctl: RTL and testbench

Hard-reset sequencing state machine for the AVMM oscillator-clock transfer enable, running on the TX oscillator clock. Consumes the fabric-side transfer enable delivered from the serial shift register. Drives the HSSI-side transfer enable toward the async capture stage and waits for that stage's synchronized echo before declaring the transfer done. It is the reset-SM endpoint of the osc-transfer handshake.

---
 rtl/c3aibadapt_avmm_hrdrst_pkg.sv | 15 +
 rtl/c3aibadapt_cmn_bitsync.sv | 24 ++
 rtl/c3aibadapt_avmm_hrdrst_osc_ctl.sv | 108 ++++++++++
 tb/tb_c3aibadapt_avmm_hrdrst_osc_ctl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3aibadapt_avmm_hrdrst_pkg.sv
// Shared types and defaults for the AVMM hard-reset oscillator-transfer sequencer.
package c3aibadapt_avmm_hrdrst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_XFER     = 3'd2,
        ST_DONE     = 3'd3,
        ST_DEASSERT = 3'd4
    } hrdrst_state_t;

    localparam int unsigned DEF_SETTLE_CNT  = 16;
    localparam int unsigned DEF_TIMEOUT_CNT = 255;

endpackage

// File: rtl/c3aibadapt_cmn_bitsync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset.
module c3aibadapt_cmn_bitsync #(
    parameter int unsigned SYNC_STAGE = 2,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGE-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGE{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/c3aibadapt_avmm_hrdrst_osc_ctl.sv
// Reset-SM endpoint of the osc-transfer handshake: settles the synchronized fabric
// enable, drives the HSSI enable and waits for its echo, flagging a sticky timeout.
module c3aibadapt_avmm_hrdrst_osc_ctl
    import c3aibadapt_avmm_hrdrst_pkg::*;
#(
    parameter int unsigned SYNC_STAGE  = 2,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SETTLE_CNT  = DEF_SETTLE_CNT,
    parameter int unsigned TIMEOUT_CNT = DEF_TIMEOUT_CNT
) (
    input  logic       avmm_clock_hrdrst_tx_osc_clk,
    input  logic       avmm_reset_hrdrst_tx_osc_clk_rst_n,
    input  logic       sr_fabric_osc_transfer_en,
    input  logic       avmm_hrdrst_hssi_osc_transfer_en_sync,
    input  logic       r_avmm_hrdrst_settle_dis,
    output logic       avmm_hrdrst_hssi_osc_transfer_en,
    output logic       avmm_hrdrst_osc_transfer_done,
    output logic       avmm_hrdrst_osc_timeout_err,
    output logic [2:0] avmm_hrdrst_osc_fsm_state
);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_MAX  = CNT_WIDTH'(TIMEOUT_CNT);

    hrdrst_state_t        state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 fab_en_s;
    logic                 echo;
    logic                 err_set;

    assign echo = avmm_hrdrst_hssi_osc_transfer_en_sync;

    c3aibadapt_cmn_bitsync #(
        .SYNC_STAGE (SYNC_STAGE),
        .RST_VAL    (1'b0)
    ) u_fab_en_sync (
        .clk   (avmm_clock_hrdrst_tx_osc_clk),
        .rst_n (avmm_reset_hrdrst_tx_osc_clk_rst_n),
        .d     (sr_fabric_osc_transfer_en),
        .q     (fab_en_s)
    );

    // cnt_nxt defaults to zero, so any state change clears the counter on entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (fab_en_s) begin
                    state_nxt = r_avmm_hrdrst_settle_dis ? ST_XFER : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!fab_en_s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = ST_XFER;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_XFER: begin
                if (!fab_en_s) begin
                    state_nxt = ST_DEASSERT;
                end else if (echo) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = (cnt == TIMEOUT_MAX) ? cnt : cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (!fab_en_s) begin
                    state_nxt = ST_DEASSERT;
                end
            end
            ST_DEASSERT: begin
                if (!echo) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign err_set = (state == ST_XFER) && !echo && (cnt == TIMEOUT_LAST);

    always_ff @(posedge avmm_clock_hrdrst_tx_osc_clk or negedge avmm_reset_hrdrst_tx_osc_clk_rst_n) begin
        if (!avmm_reset_hrdrst_tx_osc_clk_rst_n) begin
            state                            <= ST_IDLE;
            cnt                              <= '0;
            avmm_hrdrst_hssi_osc_transfer_en <= 1'b0;
            avmm_hrdrst_osc_transfer_done    <= 1'b0;
            avmm_hrdrst_osc_timeout_err      <= 1'b0;
        end else begin
            state                            <= state_nxt;
            cnt                              <= cnt_nxt;
            avmm_hrdrst_hssi_osc_transfer_en <= (state_nxt == ST_XFER) || (state_nxt == ST_DONE);
            avmm_hrdrst_osc_transfer_done    <= (state_nxt == ST_DONE);
            if (err_set) begin
                avmm_hrdrst_osc_timeout_err <= 1'b1;
            end
        end
    end

    assign avmm_hrdrst_osc_fsm_state = state;

endmodule

// File: tb/tb_c3aibadapt_avmm_hrdrst_osc_ctl.sv
// Directed bench for the oscillator-transfer hard-reset sequencer.
module tb_c3aibadapt_avmm_hrdrst_osc_ctl;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       fab        = 1'b0;
    logic       echo       = 1'b0;
    logic       settle_dis = 1'b0;
    logic       en;
    logic       done;
    logic       err;
    logic [2:0] st;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    c3aibadapt_avmm_hrdrst_osc_ctl #(
        .SYNC_STAGE  (2),
        .CNT_WIDTH   (8),
        .SETTLE_CNT  (16),
        .TIMEOUT_CNT (255)
    ) dut (
        .avmm_clock_hrdrst_tx_osc_clk          (clk),
        .avmm_reset_hrdrst_tx_osc_clk_rst_n    (rst_n),
        .sr_fabric_osc_transfer_en             (fab),
        .avmm_hrdrst_hssi_osc_transfer_en_sync (echo),
        .r_avmm_hrdrst_settle_dis              (settle_dis),
        .avmm_hrdrst_hssi_osc_transfer_en      (en),
        .avmm_hrdrst_osc_transfer_done         (done),
        .avmm_hrdrst_osc_timeout_err           (err),
        .avmm_hrdrst_osc_fsm_state             (st)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({en, done, err, st} !== 6'b0) begin
            fails++;
            $display("FAIL reset_async: got %b expected 000000", {en, done, err, st});
        end
        repeat (2) tick();
        tests++;
        if ({en, done, err, st} !== 6'b0) begin
            fails++;
            $display("FAIL reset_held: got %b expected 000000", {en, done, err, st});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (st !== 3'd0) begin
            fails++;
            $display("FAIL reset_idle: got state %0d expected 0", st);
        end
    endtask

    // Fabric rise from IDLE with settle enabled; en must appear on edge 19 exactly.
    task automatic run_rise(input string name);
        logic early;
        early = 1'b0;
        fab = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i < 19 && en !== 1'b0) early = 1'b1;
            if (i == 2) begin
                tests++;
                if (st !== 3'd0) begin
                    fails++;
                    $display("FAIL %s_st_e2: got %0d expected 0", name, st);
                end
            end
            if (i == 3 || i == 18) begin
                tests++;
                if (st !== 3'd1) begin
                    fails++;
                    $display("FAIL %s_st_e%0d: got %0d expected 1", name, i, st);
                end
            end
        end
        tests++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL %s_en_early: got %b expected 0", name, early);
        end
        tests++;
        if (en !== 1'b1 || st !== 3'd2) begin
            fails++;
            $display("FAIL %s_en_e19: got en=%b st=%0d expected en=1 st=2", name, en, st);
        end
    endtask

    task automatic go_idle(input string name);
        fab  = 1'b0;
        echo = 1'b0;
        repeat (6) tick();
        tests++;
        if (st !== 3'd0 || en !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: got st=%0d en=%b done=%b expected 0/0/0", name, st, en, done);
        end
    endtask

    task automatic test_settle_path;
        run_rise("rise1");
    endtask

    task automatic test_echo_done;
        repeat (5) tick();
        tests++;
        if (st !== 3'd2 || done !== 1'b0) begin
            fails++;
            $display("FAIL echo_wait: got st=%0d done=%b expected 2/0", st, done);
        end
        echo = 1'b1;
        tick();
        tests++;
        if (st !== 3'd3 || done !== 1'b1 || en !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL echo_done: got st=%0d done=%b en=%b err=%b expected 3/1/1/0",
                     st, done, en, err);
        end
    endtask

    task automatic test_deassert;
        fab = 1'b0;
        repeat (2) tick();
        tests++;
        if (st !== 3'd3 || done !== 1'b1) begin
            fails++;
            $display("FAIL deassert_sync: got st=%0d done=%b expected 3/1", st, done);
        end
        tick();
        tests++;
        if (st !== 3'd4 || en !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL deassert_enter: got st=%0d en=%b done=%b expected 4/0/0", st, en, done);
        end
        repeat (2) tick();
        tests++;
        if (st !== 3'd4) begin
            fails++;
            $display("FAIL deassert_hold: got st=%0d expected 4", st);
        end
        echo = 1'b0;
        tick();
        tests++;
        if (st !== 3'd0) begin
            fails++;
            $display("FAIL deassert_exit: got st=%0d expected 0", st);
        end
        run_rise("rise2");
        go_idle("after_rise2");
    endtask

    task automatic test_settle_abort;
        logic en_seen;
        en_seen = 1'b0;
        fab = 1'b1;
        repeat (9) tick();
        fab = 1'b0;
        for (int i = 10; i <= 12; i++) begin
            tick();
            if (en !== 1'b0) en_seen = 1'b1;
            if (i == 11) begin
                tests++;
                if (st !== 3'd1) begin
                    fails++;
                    $display("FAIL abort_settle: got st=%0d expected 1", st);
                end
            end
        end
        tests++;
        if (st !== 3'd0 || en_seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got st=%0d en_seen=%b expected 0/0", st, en_seen);
        end
        repeat (3) tick();
        run_rise("rise3");
        go_idle("after_rise3");
    endtask

    task automatic test_timeout;
        run_rise("rise4");
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 254) begin
                tests++;
                if (err !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_early: got err=%b expected 0", err);
                end
            end
        end
        tests++;
        if (err !== 1'b1 || st !== 3'd2) begin
            fails++;
            $display("FAIL timeout_set: got err=%b st=%0d expected 1/2", err, st);
        end
        repeat (10) tick();
        tests++;
        if (err !== 1'b1 || st !== 3'd2 || en !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got err=%b st=%0d en=%b expected 1/2/1", err, st, en);
        end
        echo = 1'b1;
        tick();
        tests++;
        if (st !== 3'd3 || done !== 1'b1 || err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_late_echo: got st=%0d done=%b err=%b expected 3/1/1", st, done, err);
        end
        go_idle("after_timeout");
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_persist: got err=%b expected 1", err);
        end
    endtask

    task automatic test_settle_dis_reset;
        settle_dis = 1'b1;
        fab = 1'b1;
        repeat (2) tick();
        tests++;
        if (en !== 1'b0) begin
            fails++;
            $display("FAIL dis_en_e2: got en=%b expected 0", en);
        end
        tick();
        tests++;
        if (en !== 1'b1 || st !== 3'd2) begin
            fails++;
            $display("FAIL dis_en_e3: got en=%b st=%0d expected 1/2", en, st);
        end
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({en, done, err, st} !== 6'b0) begin
            fails++;
            $display("FAIL midxfer_reset: got %b expected 000000", {en, done, err, st});
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        tests++;
        if (en !== 1'b0 || st !== 3'd0) begin
            fails++;
            $display("FAIL post_reset_e2: got en=%b st=%0d expected 0/0", en, st);
        end
        tick();
        tests++;
        if (en !== 1'b1 || st !== 3'd2 || err !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_e3: got en=%b st=%0d err=%b expected 1/2/0", en, st, err);
        end
    endtask

    initial begin
        test_reset();
        test_settle_path();
        test_echo_done();
        test_deassert();
        test_settle_abort();
        test_timeout();
        test_settle_dis_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
